stage_sequencer: RTL and testbench

//  Parametrised multi-cycle stage sequencer for the CPU control path; next generation of the fixed stage counter.

---
 rtl/stage_sequencer_if.sv | 34 +++
 rtl/stage_sequencer.sv | 129 ++++++++++++
 tb/tb_stage_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the stage sequencer and the units it drives.
// The master modport is the sequencer itself; the slave side supplies run/step/ack.
interface stage_sequencer_if #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned STAGE_W    = 3,
    parameter int unsigned CNT_W      = 32
);
    logic                  run;
    logic                  step;
    logic                  stall;
    logic [NUM_STAGES-1:0] skip;
    logic                  bus_ack;
    logic                  err_clr;
    logic [STAGE_W-1:0]    stage;
    logic [NUM_STAGES-1:0] stage_onehot;
    logic                  bus_req;
    logic                  stage_done;
    logic                  instr_done;
    logic                  halted;
    logic                  bus_err;
    logic [CNT_W-1:0]      retire_cnt;

    modport master (
        input  run, step, stall, skip, bus_ack, err_clr,
        output stage, stage_onehot, bus_req, stage_done, instr_done, halted, bus_err,
               retire_cnt
    );

    modport slave (
        output run, step, stall, skip, bus_ack, err_clr,
        input  stage, stage_onehot, bus_req, stage_done, instr_done, halted, bus_err,
               retire_cnt
    );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer: steps through NUM_STAGES stages with per-instruction skipping,
// req/ack memory stages with timeout, run/halt/single-step and a retired-instruction counter.
module stage_sequencer #(
    parameter int unsigned           NUM_STAGES     = 5,
    parameter int unsigned           STAGE_W        = 3,
    parameter logic [NUM_STAGES-1:0] MEM_STAGE_MASK = 5'b01001,
    parameter int unsigned           TIMEOUT        = 16,
    parameter int unsigned           CNT_W          = 32
) (
    input logic               clk,
    input logic               reset,
    stage_sequencer_if.master sif
);
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {StHalt, StRun, StError} state_e;

    state_e             state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retire_q, retire_d;
    logic               step_q, step_d;

    logic               is_mem;
    logic               complete;
    logic               stage_done;
    logic               instr_done;
    logic               nxt_found;
    logic [STAGE_W-1:0] nxt_stage;

    assign is_mem = MEM_STAGE_MASK[stage_q];

    // Lowest later stage not skipped; descending scan so the lowest match is written last.
    always_comb begin
        nxt_found = 1'b0;
        nxt_stage = '0;
        for (int t = NUM_STAGES - 1; t > 0; t--) begin
            if (t > int'(stage_q) && !sif.skip[t]) begin
                nxt_found = 1'b1;
                nxt_stage = STAGE_W'(t);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        wait_d     = '0;
        retire_d   = retire_q;
        step_d     = step_q;
        complete   = 1'b0;
        stage_done = 1'b0;
        instr_done = 1'b0;
        unique case (state_q)
            StHalt: begin
                stage_d = '0;
                if (sif.run || sif.step) begin
                    state_d = StRun;
                    step_d  = sif.step && !sif.run;
                end
            end
            StRun: begin
                if (is_mem) begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (sif.bus_ack) begin
                        complete = 1'b1;
                    end else if (TIMEOUT > 0 && wait_q == WAIT_LAST) begin
                        state_d = StError;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end else begin
                    complete = !sif.stall;
                end
                if (complete) begin
                    stage_done = 1'b1;
                    if (nxt_found) begin
                        stage_d = nxt_stage;
                    end else begin
                        instr_done = 1'b1;
                        retire_d   = retire_q + 1'b1;
                        stage_d    = '0;
                        step_d     = 1'b0;
                        if (!(sif.run && !step_q)) begin
                            state_d = StHalt;
                        end
                    end
                end
            end
            StError: begin
                if (sif.err_clr) begin
                    state_d = StHalt;
                    stage_d = '0;
                end
            end
            default: begin
                state_d = StHalt;
                stage_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StHalt;
            stage_q  <= '0;
            wait_q   <= '0;
            retire_q <= '0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            wait_q   <= wait_d;
            retire_q <= retire_d;
            step_q   <= step_d;
        end
    end

    // Completion pulses follow ack/stall in the same cycle; bus_req depends on state only.
    assign sif.stage        = stage_q;
    assign sif.stage_onehot = (state_q == StRun) ? (NUM_STAGES'(1) << stage_q) : '0;
    assign sif.bus_req      = (state_q == StRun) && is_mem;
    assign sif.stage_done   = stage_done;
    assign sif.instr_done   = instr_done;
    assign sif.halted       = (state_q == StHalt);
    assign sif.bus_err      = (state_q == StError);
    assign sif.retire_cnt   = retire_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios with literal expectations plus a per-cycle
// behavioural model of the stage/halt/error rules compared on every falling edge.
module tb_stage_sequencer;
    localparam int NS      = 5;
    localparam int TIMEOUT = 16;
    localparam int ModeHalt = 0;
    localparam int ModeRun  = 1;
    localparam int ModeErr  = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic auto_ack = 1'b1;
    logic hold_s3 = 1'b0;
    logic man_ack = 1'b0;
    logic [4:0] mem_stages = 5'b01001;

    int n_vec = 0;
    int n_bad = 0;

    int m_mode = ModeHalt;
    int m_stage = 0;
    int m_noack = 0;
    int m_ret = 0;
    bit m_shot = 1'b0;

    stage_sequencer_if #(.NUM_STAGES(5), .STAGE_W(3), .CNT_W(32)) sif ();

    stage_sequencer #(
        .NUM_STAGES(5),
        .STAGE_W(3),
        .MEM_STAGE_MASK(5'b01001),
        .TIMEOUT(16),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sif(sif)
    );

    always #5 clk = ~clk;

    // Memory responder: acks whenever requested, except while stage 3 is being held off.
    assign sif.bus_ack = auto_ack ? (sif.bus_req && !(hold_s3 && sif.stage == 3'd3)) : man_ack;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_stage(input int s, input string nm);
        int n;
        n = 0;
        while (int'(sif.stage) != s && n < 40) begin
            cyc(1);
            n++;
        end
        chk(nm, 32'(sif.stage), 32'(s));
    endtask

    always @(negedge clk) begin : model
        int n_mode, n_stage, n_noack, n_ret, nxt;
        bit n_shot, fin;
        logic [31:0] e_onehot;
        if (!reset) begin
            chk("rst_stage", 32'(sif.stage), 32'd0);
            chk("rst_halted", 32'(sif.halted), 32'd1);
            chk("rst_req", 32'(sif.bus_req), 32'd0);
            chk("rst_err", 32'(sif.bus_err), 32'd0);
            chk("rst_retire", sif.retire_cnt, 32'd0);
            m_mode  <= ModeHalt;
            m_stage <= 0;
            m_noack <= 0;
            m_ret   <= 0;
            m_shot  <= 1'b0;
        end else begin
            n_mode  = m_mode;
            n_stage = m_stage;
            n_noack = m_noack;
            n_ret   = m_ret;
            n_shot  = m_shot;
            fin     = 1'b0;
            if (m_mode == ModeRun) begin
                if (mem_stages[m_stage]) begin
                    if (sif.bus_ack) fin = 1'b1;
                    else if (m_noack + 1 == TIMEOUT) n_mode = ModeErr;
                    else n_noack = m_noack + 1;
                end else begin
                    fin = !sif.stall;
                end
            end
            nxt = m_stage + 1;
            while (nxt < NS && sif.skip[nxt]) nxt++;
            if (fin) begin
                n_noack = 0;
                if (nxt == NS) begin
                    n_ret   = m_ret + 1;
                    n_shot  = 1'b0;
                    n_stage = 0;
                    if (!(sif.run && !m_shot)) n_mode = ModeHalt;
                end else begin
                    n_stage = nxt;
                end
            end
            if (m_mode == ModeHalt && (sif.run || sif.step)) begin
                n_mode  = ModeRun;
                n_stage = 0;
                n_noack = 0;
                n_shot  = sif.step && !sif.run;
            end
            if (m_mode == ModeErr && sif.err_clr) begin
                n_mode  = ModeHalt;
                n_stage = 0;
            end
            e_onehot = (m_mode == ModeRun) ? (32'd1 << m_stage) : 32'd0;
            chk("m_stage", 32'(sif.stage), 32'(m_stage));
            chk("m_onehot", 32'(sif.stage_onehot), e_onehot);
            chk("m_req", 32'(sif.bus_req), 32'(m_mode == ModeRun && mem_stages[m_stage]));
            chk("m_stage_done", 32'(sif.stage_done), 32'(fin));
            chk("m_instr_done", 32'(sif.instr_done), 32'(fin && nxt == NS));
            chk("m_halted", 32'(sif.halted), 32'(m_mode == ModeHalt));
            chk("m_err", 32'(sif.bus_err), 32'(m_mode == ModeErr));
            chk("m_retire", sif.retire_cnt, 32'(m_ret));
            m_mode  <= n_mode;
            m_stage <= n_stage;
            m_noack <= n_noack;
            m_ret   <= n_ret;
            m_shot  <= n_shot;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish by 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq1 [6] = '{0, 1, 2, 3, 4, 0};
        int seq2 [6] = '{0, 1, 2, 0, 1, 2};
        int req2 [6] = '{1, 0, 0, 1, 0, 0};
        int don2 [6] = '{0, 0, 1, 0, 0, 1};
        sif.run = 1'b0;
        sif.step = 1'b0;
        sif.stall = 1'b0;
        sif.skip = '0;
        sif.err_clr = 1'b0;
        #1;
        chk("reset_halted", 32'(sif.halted), 32'd1);
        chk("reset_onehot", 32'(sif.stage_onehot), 32'd0);
        cyc(2);
        reset = 1'b1;

        // Free run with same-cycle acks.
        sif.run = 1'b1;
        cyc(1);
        for (int i = 0; i < 6; i++) begin
            chk("run_stage", 32'(sif.stage), 32'(seq1[i]));
            chk("run_instr_done", 32'(sif.instr_done), 32'(i == 4));
            cyc(1);
        end
        cyc(4);
        chk("run_retire10", sif.retire_cnt, 32'd2);

        // Skip stages 3 and 4.
        sif.skip = 5'b11000;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("skip_stage", 32'(sif.stage), 32'(seq2[i]));
            chk("skip_req", 32'(sif.bus_req), 32'(req2[i]));
            chk("skip_instr_done", 32'(sif.instr_done), 32'(don2[i]));
            cyc(1);
        end
        chk("skip_retire", sif.retire_cnt, 32'd4);
        sif.skip = '0;

        // Stage 3 ack held off for 4 cycles while stall toggles.
        hold_s3 = 1'b1;
        wait_stage(3, "hold_reach3");
        for (int k = 0; k < 5; k++) begin
            sif.stall = ((k % 2) == 1);
            if (k == 4) hold_s3 = 1'b0;
            #1;
            chk("hold_stage", 32'(sif.stage), 32'd3);
            chk("hold_req", 32'(sif.bus_req), 32'd1);
            chk("hold_done", 32'(sif.stage_done), 32'(k == 4));
            cyc(1);
        end
        chk("hold_next", 32'(sif.stage), 32'd4);
        chk("hold_req_drop", 32'(sif.bus_req), 32'd0);

        // No ack in stage 0 -> timeout.
        auto_ack = 1'b0;
        cyc(1);
        for (int k = 0; k < 16; k++) begin
            chk("to_err_low", 32'(sif.bus_err), 32'd0);
            chk("to_req", 32'(sif.bus_req), 32'd1);
            cyc(1);
        end
        chk("to_err", 32'(sif.bus_err), 32'd1);
        chk("to_stage", 32'(sif.stage), 32'd0);
        chk("to_req_off", 32'(sif.bus_req), 32'd0);
        chk("to_retire", sif.retire_cnt, 32'd5);
        sif.err_clr = 1'b1;
        sif.run = 1'b0;
        cyc(1);
        sif.err_clr = 1'b0;
        chk("clr_halted", 32'(sif.halted), 32'd1);
        chk("clr_err", 32'(sif.bus_err), 32'd0);
        auto_ack = 1'b1;
        sif.err_clr = 1'b1;
        cyc(1);
        sif.err_clr = 1'b0;
        chk("clr_ignored", 32'(sif.halted), 32'd1);

        // Single step.
        sif.step = 1'b1;
        cyc(1);
        sif.step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("step_stage", 32'(sif.stage), 32'(i));
            chk("step_halted", 32'(sif.halted), 32'd0);
            cyc(1);
        end
        chk("step_end_halted", 32'(sif.halted), 32'd1);
        chk("step_retire", sif.retire_cnt, 32'd6);
        cyc(1);
        chk("step_stays", 32'(sif.halted), 32'd1);

        // run dropped at stage 2 (with a stall there) -> finish then halt.
        sif.run = 1'b1;
        cyc(1);
        wait_stage(2, "drop_reach2");
        sif.run = 1'b0;
        sif.stall = 1'b1;
        #1;
        chk("drop_stall_done", 32'(sif.stage_done), 32'd0);
        cyc(1);
        chk("drop_stall_hold", 32'(sif.stage), 32'd2);
        sif.stall = 1'b0;
        #1;
        chk("drop_go_done", 32'(sif.stage_done), 32'd1);
        cyc(1);
        chk("drop_s3", 32'(sif.stage), 32'd3);
        cyc(1);
        chk("drop_s4", 32'(sif.stage), 32'd4);
        chk("drop_instr_done", 32'(sif.instr_done), 32'd1);
        cyc(1);
        chk("drop_halted", 32'(sif.halted), 32'd1);
        chk("drop_retire", sif.retire_cnt, 32'd7);

        // Async reset while requesting in stage 3.
        sif.run = 1'b1;
        hold_s3 = 1'b1;
        cyc(1);
        wait_stage(3, "arst_reach3");
        chk("arst_req_before", 32'(sif.bus_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_req", 32'(sif.bus_req), 32'd0);
        chk("arst_stage", 32'(sif.stage), 32'd0);
        chk("arst_retire", sif.retire_cnt, 32'd0);
        chk("arst_halted", 32'(sif.halted), 32'd1);
        cyc(1);
        reset = 1'b1;
        hold_s3 = 1'b0;
        sif.run = 1'b0;
        cyc(2);
        chk("final_halted", 32'(sif.halted), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
